// File: rtl/wb_daq_dma_writer.sv
`default_nettype none
// ============================================================================
// Module      : wb_daq_dma_writer
// Description : Single-channel DMA write engine. It pulls 32-bit ADC samples
//               from a valid/ready stream and writes them to consecutive word
//               addresses through a Wishbone classic master port. It reports
//               completion with a done pulse and a sticky error flag.
//               Optional build macro WB_DAQ_DMA_CIRCULAR_EN: wrap to base at
//               length and keep running until stop, error or reset.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_daq_dma_writer #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_RETRY = 15
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] base_adr,
  input  logic [15:0]   length,
  input  logic [DW-1:0] sample_dat,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic [AW-1:0] wb_master_adr_o,
  output logic [DW-1:0] wb_master_dat_o,
  output logic [3:0]    wb_master_sel_o,
  output logic          wb_master_we_o,
  output logic          wb_master_cyc_o,
  output logic          wb_master_stb_o,
  output logic [2:0]    wb_master_cti_o,
  output logic [1:0]    wb_master_bte_o,
  input  logic [DW-1:0] wb_master_dat_i,
  input  logic          wb_master_ack_i,
  input  logic          wb_master_err_i,
  input  logic          wb_master_rty_i,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [15:0]   words_written
);

  // Retry counter must be able to hold MAX_RETRY + 1 (the aborting attempt).
  localparam int              RW          = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0]   c_max_retry = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_BUS     = 3'd2,
    S_BACKOFF = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [AW-1:0]   r_base;
  logic [15:0]     r_len;
  logic [15:0]     r_cnt;
  logic [DW-1:0]   r_dat;
  logic [RW-1:0]   r_retry;
  logic            r_error;
  logic            r_wrap_done;

  logic [15:0]     w_cnt_inc;
  logic            w_last;
  logic [RW-1:0]   w_retry_inc;
  logic            w_retry_over;
  logic            w_ack_end;
  logic            w_unused;

  assign w_cnt_inc    = r_cnt + 16'd1;
  assign w_last       = (w_cnt_inc == r_len);
  assign w_retry_inc  = r_retry + RW'(1);
  assign w_retry_over = (w_retry_inc > c_max_retry);

  // In circular mode reaching length only wraps; only stop ends the run.
`ifdef WB_DAQ_DMA_CIRCULAR_EN
  assign w_ack_end = stop;
`else
  assign w_ack_end = w_last | stop;
`endif

  // Read data is never used and the word address ignores the byte lanes.
  assign w_unused = ^{wb_master_dat_i, base_adr[1:0]};

  assign wb_master_adr_o = r_base + AW'({r_cnt, 2'b00});
  assign wb_master_dat_o = r_dat;
  assign wb_master_cti_o = 3'b000;
  assign wb_master_bte_o = 2'b00;
  assign error           = r_error;
  assign words_written   = r_cnt;

  // State register; reset drops the bus cycle immediately.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and bus/handshake outputs.
  always_comb begin
    w_state_nxt     = r_state;
    sample_ready    = 1'b0;
    wb_master_cyc_o = 1'b0;
    wb_master_stb_o = 1'b0;
    wb_master_we_o  = 1'b0;
    wb_master_sel_o = 4'h0;
    busy            = 1'b1;
    done            = r_wrap_done;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = (length == 16'd0) ? S_FINISH : S_FETCH;
      end
      S_FETCH: begin
        sample_ready = 1'b1;
        if (sample_valid) w_state_nxt = S_BUS;
        else if (stop)    w_state_nxt = S_FINISH;
      end
      S_BUS: begin
        wb_master_cyc_o = 1'b1;
        wb_master_stb_o = 1'b1;
        wb_master_we_o  = 1'b1;
        wb_master_sel_o = 4'hF;
        if (wb_master_err_i)      w_state_nxt = S_FINISH;
        else if (wb_master_ack_i) w_state_nxt = w_ack_end ? S_FINISH : S_FETCH;
        else if (wb_master_rty_i) w_state_nxt = w_retry_over ? S_FINISH : S_BACKOFF;
      end
      S_BACKOFF: w_state_nxt = S_BUS;
      S_FINISH: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Transfer context, beat counter, retry counter and error flag.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_base      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_dat       <= '0;
      r_retry     <= '0;
      r_error     <= 1'b0;
      r_wrap_done <= 1'b0;
    end else begin
      r_wrap_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base  <= {base_adr[AW-1:2], 2'b00};
            r_len   <= length;
            r_cnt   <= '0;
            r_retry <= '0;
            r_error <= 1'b0;
          end
        end
        S_FETCH: begin
          if (sample_valid) r_dat <= sample_dat;
        end
        S_BUS: begin
          if (wb_master_err_i) begin
            r_error <= 1'b1;
          end else if (wb_master_ack_i) begin
            r_retry <= '0;
`ifdef WB_DAQ_DMA_CIRCULAR_EN
            if (w_last) begin
              r_cnt       <= '0;
              r_wrap_done <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
`else
            r_cnt <= w_cnt_inc;
`endif
          end else if (wb_master_rty_i) begin
            r_retry <= w_retry_inc;
            if (w_retry_over) r_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_daq_dma_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_daq_dma_writer
// Description : Self-checking bench for wb_daq_dma_writer. A queue-driven
//               Wishbone slave and a sample source feed the DUT; expected
//               writes are queued when samples are pushed and compared on
//               every bus attempt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_daq_dma_writer;

  localparam int R_ACK = 0;
  localparam int R_RTY = 1;
  localparam int R_ERR = 2;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start, stop;
  logic [31:0] base;
  logic [15:0] len;
  logic [31:0] sample_dat;
  logic        sample_valid;
  logic        sample_ready;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic        we_o, cyc_o, stb_o;
  logic [2:0]  cti_o;
  logic [1:0]  bte_o;
  logic        ack, err, rty;
  logic        busy, done, error;
  logic [15:0] ww;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          ack_cnt = 0;
  int          attempts = 0;
  int          cur_resp = R_ACK;
  bit          cyc_seen = 0;
  bit          chk_gap = 0;
  bit          hs_flag = 0;
  bit          smp_en = 0;

  wr_t         exp_q[$];
  logic [31:0] smp_q[$];
  int          resp_q[$];

  always #5 clk = ~clk;

  assign ack = cyc_o & stb_o & (cur_resp == R_ACK);
  assign rty = cyc_o & stb_o & (cur_resp == R_RTY);
  assign err = cyc_o & stb_o & (cur_resp == R_ERR);

  wb_daq_dma_writer dut (
    .wb_clk          (clk),
    .wb_rst          (rst),
    .start           (start),
    .stop            (stop),
    .base_adr        (base),
    .length          (len),
    .sample_dat      (sample_dat),
    .sample_valid    (sample_valid),
    .sample_ready    (sample_ready),
    .wb_master_adr_o (adr_o),
    .wb_master_dat_o (dat_o),
    .wb_master_sel_o (sel_o),
    .wb_master_we_o  (we_o),
    .wb_master_cyc_o (cyc_o),
    .wb_master_stb_o (stb_o),
    .wb_master_cti_o (cti_o),
    .wb_master_bte_o (bte_o),
    .wb_master_dat_i (32'hDEAD_BEEF),
    .wb_master_ack_i (ack),
    .wb_master_err_i (err),
    .wb_master_rty_i (rty),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .words_written   (ww)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_sample(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.adr = a;
    w.dat = d;
    exp_q.push_back(w);
    smp_q.push_back(d);
  endtask

  task automatic run(input logic [31:0] b, input logic [15:0] l);
    @(negedge clk);
    start = 1'b1;
    base  = b;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (done !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic flush();
    smp_en = 0;
    exp_q.delete();
    smp_q.delete();
    resp_q.delete();
  endtask

  // Sample source: retire the sample the DUT took at the last edge, then
  // present the next one.
  always @(negedge clk) begin
    if (hs_flag && smp_q.size() > 0) void'(smp_q.pop_front());
    sample_valid = smp_en && (smp_q.size() > 0);
    sample_dat   = (smp_q.size() > 0) ? smp_q[0] : 32'h0;
    hs_flag      = sample_valid && sample_ready;
  end

  // Slave and bus monitor: choose the response for each attempt and compare
  // the attempt against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (done === 1'b1) done_cnt++;
      if (cyc_o === 1'b1) cyc_seen = 1;
      if (chk_gap) begin
        chk("idle_between_attempts", {31'd0, cyc_o}, 32'd0);
        chk_gap = 0;
      end
      if (cyc_o === 1'b1 && stb_o === 1'b1) begin
        cur_resp = (resp_q.size() > 0) ? resp_q.pop_front() : R_ACK;
        attempts++;
        chk("we_sel", {27'd0, we_o, sel_o}, {27'd0, 1'b1, 4'hF});
        if (exp_q.size() == 0) begin
          chk("unexpected_write", adr_o, 32'hFFFF_FFFF);
        end else begin
          chk("wr_adr", adr_o, exp_q[0].adr);
          chk("wr_dat", dat_o, exp_q[0].dat);
          if (cur_resp != R_RTY) void'(exp_q.pop_front());
        end
        if (cur_resp == R_ACK) ack_cnt++;
        chk_gap = 1;
      end
    end
  end

  initial begin
    int d0, a0, n;
    start = 0; stop = 0; base = 0; len = 0;
    sample_valid = 0; sample_dat = 0;
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_ww", {16'd0, ww}, 32'd0);
    chk("rst_cyc_stb", {30'd0, cyc_o, stb_o}, 32'd0);
    chk("rst_adr", adr_o, 32'd0);
    chk("rst_ready", {31'd0, sample_ready}, 32'd0);
    chk("rst_cti_bte", {27'd0, cti_o, bte_o}, 32'd0);
    rst = 0;
    @(negedge clk);

    // Basic transfer of four words
    for (int i = 0; i < 4; i++) push_sample(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
    smp_en = 1;
    d0 = done_cnt; a0 = ack_cnt;
    run(32'h100, 16'd4);
    chk("basic_busy", {31'd0, busy}, 32'd1);
    wait_done(100);
    repeat (2) @(negedge clk);
    chk("basic_ww", {16'd0, ww}, 32'd4);
    chk("basic_error", {31'd0, error}, 32'd0);
    chk("basic_idle", {31'd0, busy}, 32'd0);
    chk("basic_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("basic_acks", 32'(ack_cnt - a0), 32'd4);
    chk("basic_sb_empty", 32'(exp_q.size()), 32'd0);
    flush();

    // Zero length: straight to FINISH, no bus cycle
    cyc_seen = 0;
    run(32'h180, 16'd0);
    chk("zero_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("zero_done_drop", {31'd0, done}, 32'd0);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    chk("zero_no_cyc", {31'd0, cyc_seen}, 32'd0);

    // Two retries then ack on a single beat
    resp_q = '{R_RTY, R_RTY, R_ACK};
    push_sample(32'h200, 32'h55);
    smp_en = 1;
    a0 = attempts;
    run(32'h202, 16'd1);
    wait_done(100);
    @(negedge clk);
    chk("rty_attempts", 32'(attempts - a0), 32'd3);
    chk("rty_ww", {16'd0, ww}, 32'd1);
    chk("rty_error", {31'd0, error}, 32'd0);
    flush();

    // Bus error on beat 2 of 5
    resp_q = '{R_ACK, R_ACK, R_ERR};
    for (int i = 0; i < 5; i++) push_sample(32'h300 + 32'(4 * i), 32'hC0 + 32'(i));
    smp_en = 1;
    d0 = done_cnt;
    run(32'h300, 16'd5);
    wait_done(100);
    repeat (2) @(negedge clk);
    chk("err_error", {31'd0, error}, 32'd1);
    chk("err_ww", {16'd0, ww}, 32'd2);
    chk("err_done_pulses", 32'(done_cnt - d0), 32'd1);
    flush();

    // Retry limit: 16 consecutive rty abort the transfer
    for (int i = 0; i < 16; i++) resp_q.push_back(R_RTY);
    push_sample(32'h400, 32'h77);
    smp_en = 1;
    a0 = attempts; d0 = done_cnt;
    run(32'h400, 16'd1);
    wait_done(200);
    repeat (2) @(negedge clk);
    chk("rlim_attempts", 32'(attempts - a0), 32'd16);
    chk("rlim_error", {31'd0, error}, 32'd1);
    chk("rlim_ww", {16'd0, ww}, 32'd0);
    chk("rlim_done_pulses", 32'(done_cnt - d0), 32'd1);
    flush();

    // Stop in FETCH; a start while busy must not re-latch base
    push_sample(32'h500, 32'hBEEF);
    d0 = done_cnt;
    run(32'h500, 16'd4);
    chk("start_clears_error", {31'd0, error}, 32'd0);
    run(32'h900, 16'd7);
    smp_en = 1;
    n = 0;
    while (ww !== 16'd1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stop_first_beat", {16'd0, ww}, 32'd1);
    stop = 1;
    wait_done(20);
    stop = 0;
    repeat (2) @(negedge clk);
    chk("stop_ww", {16'd0, ww}, 32'd1);
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("stop_sb_empty", 32'(exp_q.size()), 32'd0);
    flush();

`ifdef WB_DAQ_DMA_CIRCULAR_EN
    // Circular: length 2, five samples, then stop
    push_sample(32'h600, 32'hD0);
    push_sample(32'h604, 32'hD1);
    push_sample(32'h600, 32'hD2);
    push_sample(32'h604, 32'hD3);
    push_sample(32'h600, 32'hD4);
    smp_en = 1;
    d0 = done_cnt; a0 = ack_cnt;
    run(32'h600, 16'd2);
    n = 0;
    while ((ack_cnt - a0) < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("circ_four_beats", 32'(ack_cnt - a0), 32'd4);
    chk("circ_busy", {31'd0, busy}, 32'd1);
    stop = 1;
    wait_done(20);
    stop = 0;
    repeat (2) @(negedge clk);
    chk("circ_acks", 32'(ack_cnt - a0), 32'd5);
    chk("circ_done_pulses", 32'(done_cnt - d0), 32'd3);
    chk("circ_ww", {16'd0, ww}, 32'd1);
    chk("circ_busy_end", {31'd0, busy}, 32'd0);
    flush();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
